// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nco_pkg
//  Description : Shared constants and helper functions for the multi-channel
//                NCO: output lane widths, dither LFSR polynomial and seeds,
//                quarter-wave LUT depth and ROM contents.
//  Revision    : 1.0 - initial release
// ============================================================================
package nco_pkg;

    // Each channel's 32-bit tdata lane holds {cos, sin}, each 16 bits wide.
    localparam int          c_lane_w       = 16;
    localparam int          c_tdata_lane_w = 32;

    // Galois LFSR for x^32 + x^22 + x^2 + x + 1, right-shifting form.
    localparam logic [31:0] c_lfsr_poly    = 32'h8020_0003;
    localparam logic [31:0] c_default_seed = 32'h0001_8E5D;
    localparam logic [31:0] c_seed_step    = 32'h9E37_79B9;
    // Second LFSR of a channel is decorrelated from the first by this XOR.
    localparam logic [31:0] c_seed_b_xor   = 32'hA5A5_A5A5;

    localparam real         c_pi           = 3.14159265358979323846;

    // Number of entries in one quarter of the sine wave.
    function automatic int qlut_depth(input int phase_w);
        return 1 << (phase_w - 2);
    endfunction

    // Quarter-wave magnitude, sampled at half-step offsets so that no entry
    // is ever zero and the fold is exactly symmetric.
    function automatic int lut_entry(input int i, input int phase_w, input int amp_w);
        real amp;
        real ang;
        amp = real'((1 << (amp_w - 1)) - 1);
        ang = 2.0 * c_pi * (real'(i) + 0.5) / real'(1 << phase_w);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

    // Per-channel LFSR seed; sel_b picks the second generator of the pair.
    function automatic logic [31:0] chan_seed(input logic [31:0] base, input int k,
                                              input logic sel_b);
        logic [31:0] s;
        s = base ^ (32'(k) * c_seed_step);
        if (sel_b) begin
            s = s ^ c_seed_b_xor;
        end
        if (s == 32'h0) begin
            s = 32'h1;
        end
        return s;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ c_lfsr_poly) : (s >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nco_qlut.sv
`default_nettype none
// ============================================================================
//  Module      : nco_qlut
//  Description : Quarter-wave sine ROM with quadrant fold and negate, two
//                read ports (sin, cos). Two registered stages:
//                  stage 1 - fold phase into ROM index + sign flag
//                  stage 2 - ROM read and conditional negate
//  Ports       : clk, rst      clock, asynchronous active-high reset
//                en            stage advance enable
//                phase_sin/cos PHASE_W-bit phases for the two ports
//                sin_out/cos_out signed AMP_W-bit samples
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_qlut
    import nco_pkg::*;
#(
    parameter int PHASE_W = 12,
    parameter int AMP_W   = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [PHASE_W-1:0]        phase_sin,
    input  logic [PHASE_W-1:0]        phase_cos,
    output logic signed [AMP_W-1:0]   sin_out,
    output logic signed [AMP_W-1:0]   cos_out
);

    localparam int c_depth = qlut_depth(PHASE_W);
    localparam int c_idx_w = PHASE_W - 2;
    localparam int c_mag_w = AMP_W - 1;

    // ROM holds magnitudes only; the top bit of the phase supplies the sign.
    logic [c_mag_w-1:0] w_rom [c_depth];

    generate
        for (genvar i = 0; i < c_depth; i++) begin : g_rom
            assign w_rom[i] = c_mag_w'(lut_entry(i, PHASE_W, AMP_W));
        end
    endgenerate

    logic [c_idx_w-1:0]      r_idx_s;
    logic [c_idx_w-1:0]      r_idx_c;
    logic                    r_neg_s;
    logic                    r_neg_c;
    logic signed [AMP_W-1:0] w_mag_s;
    logic signed [AMP_W-1:0] w_mag_c;

    assign w_mag_s = $signed({1'b0, w_rom[r_idx_s]});
    assign w_mag_c = $signed({1'b0, w_rom[r_idx_c]});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx_s <= '0;
            r_idx_c <= '0;
            r_neg_s <= 1'b0;
            r_neg_c <= 1'b0;
            sin_out <= '0;
            cos_out <= '0;
        end else if (en) begin
            // Second and fourth quadrants read the quarter wave backwards.
            r_idx_s <= phase_sin[PHASE_W-2] ? ~phase_sin[c_idx_w-1:0] : phase_sin[c_idx_w-1:0];
            r_idx_c <= phase_cos[PHASE_W-2] ? ~phase_cos[c_idx_w-1:0] : phase_cos[c_idx_w-1:0];
            r_neg_s <= phase_sin[PHASE_W-1];
            r_neg_c <= phase_cos[PHASE_W-1];
            sin_out <= r_neg_s ? -w_mag_s : w_mag_s;
            cos_out <= r_neg_c ? -w_mag_c : w_mag_c;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nco_multi_axis.sv
`default_nettype none
// ============================================================================
//  Module      : nco_multi_axis
//  Description : Multi-channel NCO with AXI-Stream output and backpressure.
//                Pipeline: S0 accumulator, S1 phase + fold, S2 LUT read and
//                negate, S3 output register. Everything advances only when
//                the output register can accept a new sample.
//  Ports       : clk, rst            clock, asynchronous active-high reset
//                cfg_freq/cfg_phase  shadow frequency words / phase offsets
//                cfg_dither_mask     dither amplitude (NCO_DITHER_EN only)
//                cfg_load            copy shadow config to active registers
//                cfg_sync            clear all accumulators
//                m_axis_tdata/tvalid/tready  AXI-Stream master
//  Build macro : NCO_DITHER_EN enables per-channel triangular phase dither.
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_multi_axis
    import nco_pkg::*;
#(
    parameter int          NUM_CH      = 2,
    parameter int          ACC_W       = 32,
    parameter int          PHASE_W     = 12,
    parameter int          AMP_W       = 14,
    parameter logic [31:0] DITHER_SEED = 32'h0001_8E5D
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CH*ACC_W-1:0]            cfg_freq,
    input  logic [NUM_CH*PHASE_W-1:0]          cfg_phase,
    input  logic [ACC_W-1:0]                   cfg_dither_mask,
    input  logic                               cfg_load,
    input  logic                               cfg_sync,
    output logic [NUM_CH*c_tdata_lane_w-1:0]   m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready
);

    localparam logic [PHASE_W-1:0] c_quarter = PHASE_W'(qlut_depth(PHASE_W));

    logic       w_adv;
    logic       w_do_load;
    logic       w_do_sync;
    logic       r_load_pend;
    logic       r_sync_pend;
    logic       r_tvalid;
    // Fill markers for S0, S1, S2; the output stage valid is r_tvalid.
    logic [2:0] r_vld;

    assign w_adv     = ~r_tvalid | m_axis_tready;
    assign w_do_load = cfg_load | r_load_pend;
    assign w_do_sync = cfg_sync | r_sync_pend;

    assign m_axis_tvalid = r_tvalid;

    // Strobes arriving during a stall are remembered and applied on the
    // next advance so that all channels switch on the same sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_pend <= 1'b0;
            r_sync_pend <= 1'b0;
            r_vld       <= '0;
            r_tvalid    <= 1'b0;
        end else if (w_adv) begin
            r_load_pend <= 1'b0;
            r_sync_pend <= 1'b0;
            r_vld       <= {r_vld[1:0], 1'b1};
            r_tvalid    <= r_vld[2];
        end else begin
            r_load_pend <= w_do_load;
            r_sync_pend <= w_do_sync;
        end
    end

`ifndef NCO_DITHER_EN
    logic                 w_unused_dither_mask;
    localparam logic [31:0] c_unused_seed = DITHER_SEED;
    assign w_unused_dither_mask = ^cfg_dither_mask;
`endif

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            logic [ACC_W-1:0]          r_acc;
            logic [ACC_W-1:0]          r_freq;
            logic [PHASE_W-1:0]        r_phoff;
            logic [ACC_W-1:0]          w_acc_q;
            logic [PHASE_W-1:0]        w_ph_sin;
            logic [PHASE_W-1:0]        w_ph_cos;
            logic signed [AMP_W-1:0]   w_sin;
            logic signed [AMP_W-1:0]   w_cos;
            logic [c_tdata_lane_w-1:0] r_lane;

            // The accumulator holds through the very first advance after
            // reset so that the first valid sample is taken at acc = 0.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_acc   <= '0;
                    r_freq  <= '0;
                    r_phoff <= '0;
                end else if (w_adv) begin
                    if (w_do_sync) begin
                        r_acc <= '0;
                    end else if (r_vld[0]) begin
                        r_acc <= r_acc + r_freq;
                    end
                    if (w_do_load) begin
                        r_freq  <= cfg_freq[k*ACC_W +: ACC_W];
                        r_phoff <= cfg_phase[k*PHASE_W +: PHASE_W];
                    end
                end
            end

`ifdef NCO_DITHER_EN
            logic [31:0]      r_lfsr_a;
            logic [31:0]      r_lfsr_b;
            logic [ACC_W-1:0] w_dither;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_lfsr_a <= chan_seed(DITHER_SEED, k, 1'b0);
                    r_lfsr_b <= chan_seed(DITHER_SEED, k, 1'b1);
                end else if (w_adv) begin
                    r_lfsr_a <= lfsr_step(r_lfsr_a);
                    r_lfsr_b <= lfsr_step(r_lfsr_b);
                end
            end

            // Difference of two uniform values gives a triangular PDF; it
            // perturbs only the truncated phase, never the stored sum.
            assign w_dither = (ACC_W'(r_lfsr_a) & cfg_dither_mask)
                            - (ACC_W'(r_lfsr_b) & cfg_dither_mask);
            assign w_acc_q  = r_acc + w_dither;
`else
            assign w_acc_q  = r_acc;
`endif

            assign w_ph_sin = w_acc_q[ACC_W-1 -: PHASE_W] + r_phoff;
            assign w_ph_cos = w_ph_sin + c_quarter;

            nco_qlut #(
                .PHASE_W (PHASE_W),
                .AMP_W   (AMP_W)
            ) u_qlut (
                .clk       (clk),
                .rst       (rst),
                .en        (w_adv),
                .phase_sin (w_ph_sin),
                .phase_cos (w_ph_cos),
                .sin_out   (w_sin),
                .cos_out   (w_cos)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_lane <= '0;
                end else if (w_adv) begin
                    r_lane <= {c_lane_w'(w_cos), c_lane_w'(w_sin)};
                end
            end

            assign m_axis_tdata[k*c_tdata_lane_w +: c_tdata_lane_w] = r_lane;
        end
    endgenerate

endmodule
`default_nettype wire
